// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM encoding and the word-length legality check.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic bit width_ok(input int width);
        return width >= 2;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the transmitter.
// The master side offers words; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 6
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// WIDTH-bit right-shift register with synchronous clear and parallel load.
// Clear wins over load, load wins over shift; zeros enter at the MSB.
module piso_shift_reg #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (shift_en) begin
            q_d = {1'b0, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q0 = q_q[0];
endmodule

// File: rtl/piso_serializer.sv
// Serial link transmitter: accepts a word on valid/ready, sends it LSB first.
//   state | meaning
//   IDLE  | no word in flight, ready for a load
//   SHIFT | driving one bit per cycle; ready again on the last bit
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("piso_serializer: WIDTH must be at least 2");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sreg_load;
    logic             sreg_shift;
    logic             sreg_bit0;
    logic             last_bit;
    logic             accept;

    piso_shift_reg #(.WIDTH(WIDTH)) u_sreg (
        .clk      (clk),
        .clr      (rst),
        .load     (sreg_load),
        .shift_en (sreg_shift),
        .d        (bus.load_data),
        .q0       (sreg_bit0)
    );

    // Outputs decode only registered state, so nothing on the load side
    // can ripple through to the serial side in the same cycle.
    always_comb begin
        last_bit       = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        bus.load_ready = (state_q == IDLE) || last_bit;
        bus.sout_valid = (state_q == SHIFT);
        bus.sout       = (state_q == SHIFT) && sreg_bit0;
        bus.done       = last_bit;
    end

    assign accept = bus.load_valid && bus.load_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_load  = 1'b0;
        sreg_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    sreg_load = 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        sreg_load = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        sreg_shift = 1'b1;
                    end
                end else begin
                    sreg_shift = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=6): per-cycle vector table
// through an expected-value queue, a random back-to-back stream and a loopback.
module tb_piso_serializer;
    localparam int W = 6;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [W-1:0] ld;
        logic       es;
        logic       ev;
        logic       ed;
        logic       er;
        string      nm;
    } vec_t;

    typedef struct {
        logic  es;
        logic  ev;
        logic  ed;
        logic  er;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    vec_t vecs[$];
    exp_t sb[$];
    logic [W-1:0] chain = '0;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Receive end of the link: 6-stage serial-in chain, new bit enters at the top.
    always @(posedge clk) begin
        if (bus.sout_valid === 1'b1) chain <= {bus.sout, chain[W-1:1]};
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic lv, input logic [W-1:0] ld,
                                input logic es, input logic ev, input logic ed,
                                input logic er, input string nm);
        vec_t t;
        t.rst = r; t.lv = lv; t.ld = ld;
        t.es = es; t.ev = ev; t.ed = ed; t.er = er; t.nm = nm;
        vecs.push_back(t);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst            = v.rst;
        bus.load_valid = v.lv;
        bus.load_data  = v.ld;
        e.es = v.es; e.ev = v.ev; e.ed = v.ed; e.er = v.er;
        e.nm = $sformatf("%s[%0d]", v.nm, idx);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, ".sout"},       bus.sout,       e.es);
        chk({e.nm, ".sout_valid"}, bus.sout_valid, e.ev);
        chk({e.nm, ".done"},       bus.done,       e.ed);
        chk({e.nm, ".load_ready"}, bus.load_ready, e.er);
    endtask

    initial begin
        logic [W-1:0] w [4];
        logic [W-1:0] pat;
        bit           seen;

        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // reset then idle for 10 cycles
        add(1, 0, 6'h00, 0, 0, 0, 1, "reset");
        add(1, 1, 6'h3F, 0, 0, 0, 1, "reset");
        for (int i = 0; i < 10; i++) add(0, 0, 6'h00, 0, 0, 0, 1, "idle");

        // single word 101101 -> 1,0,1,1,0,1
        add(0, 1, 6'b101101, 1, 1, 0, 0, "single");
        add(0, 0, 6'h00,     0, 1, 0, 0, "single");
        add(0, 0, 6'h00,     1, 1, 0, 0, "single");
        add(0, 0, 6'h00,     1, 1, 0, 0, "single");
        add(0, 0, 6'h00,     0, 1, 0, 0, "single");
        add(0, 0, 6'h00,     1, 1, 1, 1, "single");
        add(0, 0, 6'h00,     0, 0, 0, 1, "single");

        // back-to-back 2A then 15
        add(0, 1, 6'h2A, 0, 1, 0, 0, "b2b");
        add(0, 1, 6'h2A, 1, 1, 0, 0, "b2b");
        add(0, 1, 6'h2A, 0, 1, 0, 0, "b2b");
        add(0, 1, 6'h2A, 1, 1, 0, 0, "b2b");
        add(0, 1, 6'h2A, 0, 1, 0, 0, "b2b");
        add(0, 1, 6'h2A, 1, 1, 1, 1, "b2b");
        add(0, 1, 6'h15, 1, 1, 0, 0, "b2b");
        add(0, 1, 6'h15, 0, 1, 0, 0, "b2b");
        add(0, 1, 6'h15, 1, 1, 0, 0, "b2b");
        add(0, 1, 6'h15, 0, 1, 0, 0, "b2b");
        add(0, 1, 6'h15, 1, 1, 0, 0, "b2b");
        add(0, 0, 6'h00, 0, 1, 1, 1, "b2b");
        add(0, 0, 6'h00, 0, 0, 0, 1, "b2b");

        // load attempt while busy is ignored
        add(0, 1, 6'h3F, 1, 1, 0, 0, "busy");
        add(0, 0, 6'h00, 1, 1, 0, 0, "busy");
        add(0, 0, 6'h00, 1, 1, 0, 0, "busy");
        add(0, 1, 6'h00, 1, 1, 0, 0, "busy");
        add(0, 0, 6'h00, 1, 1, 0, 0, "busy");
        add(0, 0, 6'h00, 1, 1, 1, 1, "busy");
        add(0, 0, 6'h00, 0, 0, 0, 1, "busy");
        add(0, 0, 6'h00, 0, 0, 0, 1, "busy");

        // reset in cycle 3 of a word, then a clean 6'h01
        add(0, 1, 6'h3F, 1, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 1, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 1, 1, 0, 0, "rstmid");
        add(1, 0, 6'h00, 0, 0, 0, 1, "rstmid");
        add(0, 0, 6'h00, 0, 0, 0, 1, "rstmid");
        add(0, 0, 6'h00, 0, 0, 0, 1, "rstmid");
        add(0, 0, 6'h00, 0, 0, 0, 1, "rstmid");
        add(0, 1, 6'h01, 1, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 0, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 0, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 0, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 0, 1, 0, 0, "rstmid");
        add(0, 0, 6'h00, 0, 1, 1, 1, "rstmid");
        add(0, 0, 6'h00, 0, 0, 0, 1, "rstmid");

        // random words streamed with load_valid held high
        for (int j = 0; j < 4; j++) w[j] = W'($urandom);
        for (int j = 0; j < 4; j++) begin
            pat = w[j];
            for (int i = 0; i < W; i++)
                add(0, 1, pat, pat[i], 1, (i == W - 1), (i == W - 1), "stream");
        end
        add(0, 0, 6'h00, 0, 0, 0, 1, "stream");

        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

        // loopback: 6'h1B must land in the receive chain after the done cycle
        rst            = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 6'h1B;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_data  = 6'h00;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL loopback.done_timeout: got no done within 20 cycles, expected one");
        end else begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (chain !== 6'h1B) begin
                n_fail++;
                $display("FAIL loopback.chain: got %h expected %h", chain, 6'h1B);
            end
            chk("loopback.idle_after", bus.sout_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB first. It is the transmit end of the serial link whose receive end is the 6-stage serial-in shift chain. Bit ordering is fixed so that after WIDTH shifts, receiver stage i holds load_data[i]. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, default 6: word length in bits; legal range WIDTH >= 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  a word is offered on load_data.
- load_data  input  WIDTH  parallel word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data, LSB first.
- sout_valid  output  1  sout carries a data bit this cycle.
- done  output  1  one-cycle pulse marking the last bit of a word.

## Operation
- Single clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Internal state:
  - FSM with states IDLE and SHIFT.
  - WIDTH-bit shift register sreg.
  - Bit counter cnt, $clog2(WIDTH) bits wide, counting 0 to WIDTH-1. No wrap beyond WIDTH-1.
- Reset: state=IDLE, sreg=0, cnt=0. Outputs: sout=0, sout_valid=0, done=0, load_ready=1.
- Accept condition: load_valid && load_ready at a clock edge. On acceptance, sreg<=load_data, cnt<=0, state<=SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0, done=0.
  - Stay in IDLE until an accept.
- SHIFT:
  - sout=sreg[0], sout_valid=1.
  - Each edge: sreg shifts right by one with zero fill, and cnt increments.
- Last bit (cnt==WIDTH-1):
  - done=1 and load_ready=1 in this cycle.
  - If an accept occurs at the closing edge: reload sreg, set cnt=0, stay in SHIFT.
  - Otherwise go to IDLE.
- Busy (SHIFT with cnt<WIDTH-1):
  - load_ready=0.
  - load_valid is ignored, and changes on load_data have no effect on the word in flight.
- Reset mid-word: aborts the word immediately. No done pulse; outputs take their reset values the next cycle.
- Outputs sout, sout_valid, done and load_ready are functions of registered state only. No combinational path from any input to any output.

## Timing
- Accept at edge k: bit i appears on sout during cycle k+1+i, for i = 0 to WIDTH-1.
- done is high in cycle k+WIDTH only.
- Latency from accept to first bit: 1 cycle. Word duration: WIDTH cycles.
- Throughput: one word per WIDTH cycles when load_valid is held high. sout_valid stays continuously 1 across word boundaries.
- A receiver sampling sout on every edge where sout_valid=1 holds the complete word from the edge that ends the done cycle.
- Reset asserted at edge r: cycle r+1 shows IDLE values, regardless of state at edge r.

## Structure
- Shared package holds:
  - state encodings: IDLE=1'b0, SHIFT=1'b1;
  - the WIDTH legality check.
- Natural sub-module: piso_shift_reg, a WIDTH-bit register with synchronous clear, parallel load, shift-right enable, and a q[0] tap.
- The FSM, counter and handshake live in piso_serializer.

## Test plan
All scenarios use WIDTH=6.
- Single word: load 6'b101101 with load_valid for one cycle -> sout = 1,0,1,1,0,1 in cycles 1–6 after accept; sout_valid=1 for those 6 cycles; done only in cycle 6; load_ready=0 in cycles 1–5.
- Back-to-back: hold load_valid=1 with 6'h2A, then 6'h15 -> 12 contiguous valid bits 0,1,0,1,0,1,1,0,1,0,1,0; done in cycles 6 and 12; no gap.
- Load while busy: accept 6'h3F, then pulse load_valid with 6'h00 in cycle 3 -> sout stays all 1s for the word; the 6'h00 is not transmitted; returns to IDLE.
- Reset mid-word: accept 6'h3F, assert rst in cycle 3 -> from cycle 4, sout=0, sout_valid=0, done=0, load_ready=1; no done pulse; a subsequent load of 6'h01 transmits correctly.
- Loopback: drive sout into a 6-stage serial-in chain enabled by sout_valid; send 6'h1B -> chain parallel output equals 6'h1B after the edge closing the done cycle.
- Idle and reset values: after rst with load_valid=0 for 10 cycles -> load_ready=1, sout=0, sout_valid=0, done=0 throughout.
